// File: rtl/axi4_lite_slave_handshake_ctrl_pkg.sv
// Shared FSM state types and default timing constants for the AXI4-Lite slave
// handshake controller.
package Axi4LiteGlobalsPkg;

    typedef enum logic [1:0] {
        WR_COLLECT = 2'd0,
        WR_LAT     = 2'd1,
        WR_RESP    = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_LAT  = 2'd1,
        RD_RESP = 2'd2
    } rd_state_e;

    localparam int DEF_AW_READY_DELAY = 0;
    localparam int DEF_W_READY_DELAY  = 0;
    localparam int DEF_AR_READY_DELAY = 0;
    localparam int DEF_B_LATENCY      = 0;
    localparam int DEF_R_LATENCY      = 0;
    localparam int DEF_CNT_WIDTH      = 16;

    // Width of a counter holding 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axi4_lite_slave_handshake_ctrl_ready_delay.sv
// Programmable ready wait-state generator for one AXI4-Lite address/data channel.
// 'eligible' is the channel's eligibility for the coming cycle.
module axi4_lite_ready_delay
    import Axi4LiteGlobalsPkg::*;
#(
    parameter int DELAY = 0
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic eligible,
    input  logic valid,
    output logic ready
);

    localparam int CW = cnt_w(DELAY);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          eligible_q;
    logic          ready_nxt;

    // A handshake, a dropped valid or loss of eligibility all restart the wait.
    always_comb begin
        cnt_nxt = '0;
        if (eligible_q && valid && !ready) begin
            if (cnt < CW'(DELAY)) begin
                cnt_nxt = cnt + CW'(1);
            end else begin
                cnt_nxt = cnt;
            end
        end
        ready_nxt = eligible && ((DELAY == 0) || (cnt_nxt >= CW'(DELAY)));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt        <= '0;
            eligible_q <= 1'b0;
            ready      <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            eligible_q <= eligible;
            ready      <= ready_nxt;
        end
    end

endmodule

// File: rtl/axi4_lite_slave_handshake_ctrl.sv
// AXI4-Lite slave responder: programmable ready wait-states, response latencies,
// accept strobes and wrapping completion counters. One write and one read in flight.
//
// state      | meaning
// WR_COLLECT | accepting AW and W, either order
// WR_LAT     | counting B latency
// WR_RESP    | bvalid held until bready
// RD_IDLE    | waiting for AR handshake
// RD_LAT     | counting R latency
// RD_RESP    | rvalid held until rready
module axi4_lite_slave_handshake_ctrl
    import Axi4LiteGlobalsPkg::*;
#(
    parameter int AW_READY_DELAY = DEF_AW_READY_DELAY,
    parameter int W_READY_DELAY  = DEF_W_READY_DELAY,
    parameter int AR_READY_DELAY = DEF_AR_READY_DELAY,
    parameter int B_LATENCY      = DEF_B_LATENCY,
    parameter int R_LATENCY      = DEF_R_LATENCY,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic                 wvalid,
    output logic                 wready,
    output logic                 bvalid,
    input  logic                 bready,
    input  logic                 arvalid,
    output logic                 arready,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 wr_accept,
    output logic                 rd_accept,
    output logic [CNT_WIDTH-1:0] wr_done_count,
    output logic [CNT_WIDTH-1:0] rd_done_count
);

    localparam int BLW = cnt_w(B_LATENCY);
    localparam int RLW = cnt_w(R_LATENCY);

    wr_state_e      wr_state;
    rd_state_e      rd_state;
    logic           aw_done;
    logic           w_done;
    logic [BLW-1:0] b_cnt;
    logic [RLW-1:0] r_cnt;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic aw_elig;
    logic w_elig;
    logic ar_elig;

    assign aw_hs = awready & awvalid;
    assign w_hs  = wready & wvalid;
    assign ar_hs = arready & arvalid;

    // Eligibility for the next cycle, so ready reopens right after a B/R handshake.
    assign aw_elig = ((wr_state == WR_COLLECT) && !aw_done && !aw_hs) ||
                     ((wr_state == WR_RESP) && bready);
    assign w_elig  = ((wr_state == WR_COLLECT) && !w_done && !w_hs) ||
                     ((wr_state == WR_RESP) && bready);
    assign ar_elig = ((rd_state == RD_IDLE) && !ar_hs) ||
                     ((rd_state == RD_RESP) && rready);

    axi4_lite_ready_delay #(.DELAY(AW_READY_DELAY)) u_aw_ready (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .eligible (aw_elig),
        .valid    (awvalid),
        .ready    (awready)
    );

    axi4_lite_ready_delay #(.DELAY(W_READY_DELAY)) u_w_ready (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .eligible (w_elig),
        .valid    (wvalid),
        .ready    (wready)
    );

    axi4_lite_ready_delay #(.DELAY(AR_READY_DELAY)) u_ar_ready (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .eligible (ar_elig),
        .valid    (arvalid),
        .ready    (arready)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state      <= WR_COLLECT;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            b_cnt         <= '0;
            bvalid        <= 1'b0;
            wr_accept     <= 1'b0;
            wr_done_count <= '0;
        end else begin
            wr_accept <= 1'b0;
            case (wr_state)
                WR_COLLECT: begin
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        wr_accept <= 1'b1;
                        if (B_LATENCY == 0) begin
                            wr_state <= WR_RESP;
                            bvalid   <= 1'b1;
                        end else begin
                            wr_state <= WR_LAT;
                            b_cnt    <= BLW'(B_LATENCY - 1);
                        end
                    end
                end
                WR_LAT: begin
                    if (b_cnt == '0) begin
                        wr_state <= WR_RESP;
                        bvalid   <= 1'b1;
                    end else begin
                        b_cnt <= b_cnt - BLW'(1);
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid        <= 1'b0;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        wr_done_count <= wr_done_count + CNT_WIDTH'(1);
                        wr_state      <= WR_COLLECT;
                    end
                end
                default: begin
                    wr_state <= WR_COLLECT;
                    bvalid   <= 1'b0;
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state      <= RD_IDLE;
            r_cnt         <= '0;
            rvalid        <= 1'b0;
            rd_accept     <= 1'b0;
            rd_done_count <= '0;
        end else begin
            rd_accept <= 1'b0;
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_accept <= 1'b1;
                        if (R_LATENCY == 0) begin
                            rd_state <= RD_RESP;
                            rvalid   <= 1'b1;
                        end else begin
                            rd_state <= RD_LAT;
                            r_cnt    <= RLW'(R_LATENCY - 1);
                        end
                    end
                end
                RD_LAT: begin
                    if (r_cnt == '0) begin
                        rd_state <= RD_RESP;
                        rvalid   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - RLW'(1);
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid        <= 1'b0;
                        rd_done_count <= rd_done_count + CNT_WIDTH'(1);
                        rd_state      <= RD_IDLE;
                    end
                end
                default: begin
                    rd_state <= RD_IDLE;
                    rvalid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_handshake_ctrl.sv
// Directed bench: three controller instances (zero delays, wait-state/latency, 2-bit counters).
module tb_axi4_lite_slave_handshake_ctrl;

    logic aclk;
    logic aresetn;

    // Shared stimulus for the zero-delay instances d0 (16-bit counts) and d2 (2-bit counts)
    logic s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    // Stimulus for d1 (B_LATENCY=2, AR_READY_DELAY=3, R_LATENCY=1)
    logic t_awvalid, t_wvalid, t_bready, t_arvalid, t_rready;

    logic        d0_awready, d0_wready, d0_bvalid, d0_arready, d0_rvalid, d0_wr_accept, d0_rd_accept;
    logic [15:0] d0_wr_done_count, d0_rd_done_count;
    logic        d1_awready, d1_wready, d1_bvalid, d1_arready, d1_rvalid, d1_wr_accept, d1_rd_accept;
    logic [15:0] d1_wr_done_count, d1_rd_done_count;
    logic        d2_awready, d2_wready, d2_bvalid, d2_arready, d2_rvalid, d2_wr_accept, d2_rd_accept;
    logic [1:0]  d2_wr_done_count, d2_rd_done_count;

    int n_total = 0;
    int n_bad   = 0;

    axi4_lite_slave_handshake_ctrl u_d0 (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(s_awvalid), .awready(d0_awready),
        .wvalid(s_wvalid), .wready(d0_wready),
        .bvalid(d0_bvalid), .bready(s_bready),
        .arvalid(s_arvalid), .arready(d0_arready),
        .rvalid(d0_rvalid), .rready(s_rready),
        .wr_accept(d0_wr_accept), .rd_accept(d0_rd_accept),
        .wr_done_count(d0_wr_done_count), .rd_done_count(d0_rd_done_count)
    );

    axi4_lite_slave_handshake_ctrl #(
        .B_LATENCY(2), .AR_READY_DELAY(3), .R_LATENCY(1)
    ) u_d1 (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(t_awvalid), .awready(d1_awready),
        .wvalid(t_wvalid), .wready(d1_wready),
        .bvalid(d1_bvalid), .bready(t_bready),
        .arvalid(t_arvalid), .arready(d1_arready),
        .rvalid(d1_rvalid), .rready(t_rready),
        .wr_accept(d1_wr_accept), .rd_accept(d1_rd_accept),
        .wr_done_count(d1_wr_done_count), .rd_done_count(d1_rd_done_count)
    );

    axi4_lite_slave_handshake_ctrl #(.CNT_WIDTH(2)) u_d2 (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(s_awvalid), .awready(d2_awready),
        .wvalid(s_wvalid), .wready(d2_wready),
        .bvalid(d2_bvalid), .bready(s_bready),
        .arvalid(s_arvalid), .arready(d2_arready),
        .rvalid(d2_rvalid), .rready(s_rready),
        .wr_accept(d2_wr_accept), .rd_accept(d2_rd_accept),
        .wr_done_count(d2_wr_done_count), .rd_done_count(d2_rd_done_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One zero-delay write on d0/d2 with bready already high; checks the final counts.
    task automatic shared_write(input int exp0, input int exp2);
        @(negedge aclk);
        chk("sw_awready", 32'(d0_awready), 1);
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_bready  = 1'b1;
        @(negedge aclk);
        chk("sw_accept", 32'(d0_wr_accept), 1);
        chk("sw_bvalid", 32'(d0_bvalid), 1);
        chk("sw_rdy_low", 32'({d0_awready, d0_wready}), 0);
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        @(negedge aclk);
        chk("sw_cnt0", 32'(d0_wr_done_count), exp0);
        chk("sw_cnt2", 32'(d2_wr_done_count), exp2);
        chk("sw_bvalid_low", 32'(d0_bvalid), 0);
        s_bready = 1'b0;
    endtask

    initial begin
        aresetn   = 1'b0;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0; s_arvalid = 1'b0; s_rready = 1'b0;
        t_awvalid = 1'b0; t_wvalid = 1'b0; t_bready = 1'b0; t_arvalid = 1'b0; t_rready = 1'b0;

        // Reset state
        repeat (2) @(negedge aclk);
        chk("rst_d0_out", 32'({d0_awready, d0_wready, d0_bvalid, d0_arready, d0_rvalid,
                               d0_wr_accept, d0_rd_accept}), 0);
        chk("rst_d0_cnt", 32'({d0_wr_done_count, d0_rd_done_count}), 0);
        chk("rst_d1_out", 32'({d1_awready, d1_wready, d1_bvalid, d1_arready, d1_rvalid}), 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_d0_out", 32'({d0_awready, d0_wready, d0_arready, d0_bvalid, d0_rvalid}), 32'b11100);
        chk("rel_d0_cnt", 32'({d0_wr_done_count, d0_rd_done_count}), 0);
        chk("rel_d1_arready", 32'(d1_arready), 0);

        // d1: W before AW, B_LATENCY = 2
        chk("w_ready", 32'(d1_wready), 1);
        t_wvalid = 1'b1;
        @(negedge aclk);
        chk("w_fall", 32'(d1_wready), 0);
        chk("w_aw_open", 32'(d1_awready), 1);
        t_wvalid = 1'b0;
        @(negedge aclk);
        chk("w_no_accept", 32'(d1_wr_accept), 0);
        chk("w_stays_low", 32'(d1_wready), 0);
        @(negedge aclk);
        chk("aw_ready", 32'(d1_awready), 1);
        t_awvalid = 1'b1;
        @(negedge aclk);
        chk("wr_accept", 32'(d1_wr_accept), 1);
        chk("aw_fall", 32'(d1_awready), 0);
        chk("lat_bvalid0", 32'(d1_bvalid), 0);
        t_awvalid = 1'b0;
        @(negedge aclk);
        chk("wr_accept_end", 32'(d1_wr_accept), 0);
        chk("lat_bvalid1", 32'(d1_bvalid), 0);
        @(negedge aclk);
        chk("bvalid_rise", 32'(d1_bvalid), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("bvalid_hold", 32'(d1_bvalid), 1);
            chk("hold_cnt", 32'(d1_wr_done_count), 0);
        end
        t_bready = 1'b1;
        @(negedge aclk);
        chk("b_done_valid", 32'(d1_bvalid), 0);
        chk("b_done_cnt", 32'(d1_wr_done_count), 1);
        chk("b_done_rdy", 32'({d1_awready, d1_wready}), 32'b11);
        t_bready = 1'b0;

        // d1: AR_READY_DELAY = 3 with a dropped valid, R_LATENCY = 1
        @(negedge aclk);
        chk("ar_idle", 32'(d1_arready), 0);
        t_arvalid = 1'b1;
        @(negedge aclk);
        chk("ar_wait1", 32'(d1_arready), 0);
        @(negedge aclk);
        chk("ar_wait2", 32'(d1_arready), 0);
        t_arvalid = 1'b0;
        @(negedge aclk);
        chk("ar_drop", 32'(d1_arready), 0);
        t_arvalid = 1'b1;
        @(negedge aclk);
        chk("ar_restart1", 32'(d1_arready), 0);
        @(negedge aclk);
        chk("ar_restart2", 32'(d1_arready), 0);
        @(negedge aclk);
        chk("ar_rise", 32'(d1_arready), 1);
        @(negedge aclk);
        chk("ar_fall", 32'(d1_arready), 0);
        chk("rd_accept", 32'(d1_rd_accept), 1);
        chk("r_lat", 32'(d1_rvalid), 0);
        t_arvalid = 1'b0;
        @(negedge aclk);
        chk("rvalid_rise", 32'(d1_rvalid), 1);
        chk("rd_accept_end", 32'(d1_rd_accept), 0);
        t_rready = 1'b1;
        @(negedge aclk);
        chk("r_done_valid", 32'(d1_rvalid), 0);
        chk("r_done_cnt", 32'(d1_rd_done_count), 1);
        chk("ar_rewait", 32'(d1_arready), 0);
        t_rready = 1'b0;

        // d0/d2: write and read completing together
        @(negedge aclk);
        chk("sim_rdy", 32'({d0_awready, d0_wready, d0_arready}), 32'b111);
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        s_bready  = 1'b1; s_rready = 1'b1;
        @(negedge aclk);
        chk("sim_accepts", 32'({d0_wr_accept, d0_rd_accept}), 32'b11);
        chk("sim_valids", 32'({d0_bvalid, d0_rvalid}), 32'b11);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        @(negedge aclk);
        chk("sim_wr_cnt", 32'(d0_wr_done_count), 1);
        chk("sim_rd_cnt", 32'(d0_rd_done_count), 1);
        chk("sim_wr_cnt2", 32'(d2_wr_done_count), 1);
        chk("sim_rdy_back", 32'({d0_awready, d0_wready, d0_arready}), 32'b111);
        s_bready = 1'b0; s_rready = 1'b0;

        // Counter wrap on d2: 1 (above), 2, 3, 0, 1
        shared_write(2, 2);
        shared_write(3, 3);
        shared_write(4, 0);
        shared_write(5, 1);

        // Asynchronous reset with bvalid pending and wr_done_count = 5
        @(negedge aclk);
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        @(negedge aclk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("pre_rst_bvalid", 32'(d0_bvalid), 1);
        chk("pre_rst_cnt", 32'(d0_wr_done_count), 5);
        #2 aresetn = 1'b0;
        #1;
        chk("async_bvalid", 32'(d0_bvalid), 0);
        chk("async_cnt", 32'(d0_wr_done_count), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_rdy", 32'({d0_awready, d0_wready, d0_bvalid}), 32'b110);
        shared_write(1, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
